// File: rtl/ram_1p_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data ports.
// Data has fixed priority; a streak counter forces a fetch through after MaxDataStreak contended data grants.
module ram_1p_arbiter #(
  parameter logic [31:0] MemStart      = 32'h0000_0000,
  parameter int unsigned MemSize       = 65536,
  parameter int unsigned MaxDataStreak = 4,
  parameter int unsigned MemAw         = $clog2(MemSize / 4)
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,

  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,

  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,

  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam logic [31:0] AddrMask  = ~(32'(MemSize) - 32'd1);
  localparam logic [3:0]  StreakMax = 4'(MaxDataStreak);

  logic       instr_in_range;
  logic       data_in_range;
  logic       instr_gnt;
  logic       data_gnt;
  logic [3:0] streak_q;
  logic [3:0] streak_next;
  logic       rsp_instr_q;
  logic       rsp_data_q;
  logic       rsp_err_q;
  logic       unused_addr_bits;

  // Byte offset within a word has no meaning to a word-wide SRAM.
  assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  assign instr_in_range = (instr_addr_i & AddrMask) == MemStart;
  assign data_in_range  = (data_addr_i & AddrMask) == MemStart;

  // Data wins contention until the streak reaches its limit, then fetch gets one slot.
  assign instr_gnt = instr_req_i & (~data_req_i | (streak_q == StreakMax));
  assign data_gnt  = data_req_i & ~instr_gnt;

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  always_comb begin
    streak_next = streak_q;
    if (!instr_req_i || instr_gnt) begin
      streak_next = 4'd0;
    end else if (data_gnt && (streak_q < StreakMax)) begin
      streak_next = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_next;
    end
  end

  // Out-of-range grants still consume the slot but never touch the SRAM.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (instr_gnt && instr_in_range) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i[MemAw+1:2];
    end else if (data_gnt && data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i[MemAw+1:2];
      mem_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rsp_instr_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_instr_q <= instr_gnt;
      rsp_data_q  <= data_gnt;
      rsp_err_q   <= (instr_gnt & ~instr_in_range) | (data_gnt & ~data_in_range);
    end
  end

  assign instr_rvalid_o = rsp_instr_q;
  assign instr_err_o    = rsp_instr_q & rsp_err_q;
  assign instr_rdata_o  = (rsp_instr_q && !rsp_err_q) ? mem_rdata_i : 32'h0;

  assign data_rvalid_o  = rsp_data_q;
  assign data_err_o     = rsp_data_q & rsp_err_q;
  assign data_rdata_o   = (rsp_data_q && !rsp_err_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Scoreboard bench for ram_1p_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares whatever the DUT returns.
module tb_ram_1p_arbiter;

  localparam int Words = 16384;
  localparam int MaxS  = 4;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = 32'h0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0, data_wdata_i = 32'h0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  ram_1p_arbiter dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        qi[$];
  rsp_t        qd[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [Words];
  logic [3:0]  m_streak = 4'd0;
  logic [31:0] sram [Words];
  bit          sram_ready = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32) return 32'h0000_0013;
    if (i == 64) return 32'h1122_3344;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a & 32'hFFFF_0000) == 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port SRAM with 1-cycle registered read.
  always @(posedge clk_sys) begin
    if (!sram_ready) begin
      for (int i = 0; i < Words; i++) sram[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else if (mem_req_o) begin
      mem_rdata_i <= sram[mem_addr_o];
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end
    end
  end

  // Monitor: every grant must be answered exactly one cycle later.
  always @(negedge clk_sys) begin
    rsp_t r;
    if (!rst_sys_n) begin
      qi.delete();
      qd.delete();
    end else begin
      chk("instr_rvalid", 64'(instr_rvalid_o), 64'(qi.size() != 0));
      if (qi.size() != 0) begin
        r = qi.pop_front();
        chk("instr_err", 64'(instr_err_o), 64'(r.err));
        if (r.chk) chk("instr_rdata", 64'(instr_rdata_o), 64'(r.rdata));
        $display("rsp instr err=%0b rdata=%h", instr_err_o, instr_rdata_o);
      end
      chk("data_rvalid", 64'(data_rvalid_o), 64'(qd.size() != 0));
      if (qd.size() != 0) begin
        r = qd.pop_front();
        chk("data_err", 64'(data_err_o), 64'(r.err));
        if (r.chk) chk("data_rdata", 64'(data_rdata_o), 64'(r.rdata));
        $display("rsp data  err=%0b rdata=%h", data_err_o, data_rdata_o);
      end
    end
  end

  // One bus cycle: drive, check grant and SRAM strobe, push expected responses.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] db, input logic [31:0] da, input logic [31:0] dwd,
                      output logic gi, output logic gd);
    logic        egi, egd, iir, dir;
    logic [51:0] exp_bus;
    logic [13:0] wi, wd;
    logic [31:0] mask;
    @(negedge clk_sys);
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dw; data_be_i = db; data_addr_i = da; data_wdata_i = dwd;
    #2;
    iir = in_range(ia); dir = in_range(da);
    wi = ia[15:2]; wd = da[15:2];
    egi = ir && (!dr || (m_streak == 4'(MaxS)));
    egd = dr && !egi;
    chk("streak_q", 64'(dut.streak_q), 64'(m_streak));
    chk("instr_gnt", 64'(instr_gnt_o), 64'(egi));
    chk("data_gnt", 64'(data_gnt_o), 64'(egd));
    exp_bus = '0;
    if (egi && iir) exp_bus = {1'b1, 1'b0, 4'hF, wi, 32'h0};
    else if (egd && dir) exp_bus = {1'b1, dw, db, wd, dwd};
    chk("mem_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(exp_bus));
    if (egi) qi.push_back(iir ? rsp_t'{1'b0, 1'b1, model_mem[wi]} : rsp_t'{1'b1, 1'b1, 32'h0});
    if (egd) begin
      if (!dir) qd.push_back(rsp_t'{1'b1, 1'b1, 32'h0});
      else if (dw) begin
        qd.push_back(rsp_t'{1'b0, 1'b0, 32'h0});
        mask = {{8{db[3]}}, {8{db[2]}}, {8{db[1]}}, {8{db[0]}}};
        model_mem[wd] = (model_mem[wd] & ~mask) | (dwd & mask);
      end else qd.push_back(rsp_t'{1'b0, 1'b1, model_mem[wd]});
    end
    if (!ir || egi) m_streak = 4'd0;
    else if (egd && m_streak < 4'(MaxS)) m_streak = m_streak + 4'd1;
    $display("cyc ireq=%0b dreq=%0b gnt_i=%0b gnt_d=%0b streak=%0d", ir, dr, instr_gnt_o, data_gnt_o, dut.streak_q);
    gi = egi; gd = egd;
  endtask

  task automatic idle();
    logic gi, gd;
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gi, gd;
    logic [9:0] pat;
    for (int i = 0; i < Words; i++) model_mem[i] = init_word(i);

    // Reset state
    #3;
    chk("rst_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'h0);
    chk("rst_rsp", 64'({instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o}), 64'h0);
    chk("rst_rdata", 64'({instr_rdata_o, data_rdata_o}), 64'h0);
    chk("rst_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'h0);
    chk("rst_streak", 64'(dut.streak_q), 64'h0);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    idle();

    // Single fetch from word 32
    step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("fetch_addr32", 64'(mem_addr_o), 64'd32);
    idle();

    // Partial store then load of the same word, back to back
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gd);
    idle();
    chk("sram_word64", 64'(sram[64]), 64'h1122CCDD);

    // Out-of-range load and store
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0, gi, gd);
    chk("oor_gnt", 64'(data_gnt_o), 64'h1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0001_0100, 32'hFFFF_FFFF, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gd);
    idle();
    chk("oor_store_dropped", 64'(sram[64]), 64'h1122CCDD);

    // Continuous contention: D,D,D,D,I repeating
    pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h80 + 32'(4 * i), 1'b1, 1'b0, 4'hF, 32'h400 + 32'(4 * i), 32'h0, gi, gd);
      chk("contention_instr", 64'(gi), 64'(pat[i]));
    end
    idle();

    // Interleaved streams: fetch every cycle, data every other cycle
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 32'h200 + 32'(4 * k), (k % 2) == 0, (k % 4) == 2, 4'hF,
           32'h300, 32'h5500_0000 | 32'(k), gi, gd);
    end
    idle();

    // Reset while a data response is pending and the streak is non-zero
    step(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gd);
    @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b0;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    m_streak = 4'd0;
    #1;
    chk("midrst_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'h0);
    chk("midrst_err", 64'({instr_err_o, data_err_o}), 64'h0);
    chk("midrst_streak", 64'(dut.streak_q), 64'h0);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    idle();
    step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("postrst_addr32", 64'(mem_addr_o), 64'd32);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_1p_arbiter.md
# ram_1p_arbiter

Shares one single-port SRAM between the Ibex instruction and data ports, replacing the dual-port RAM in the FPGA top levels so the memory maps onto one BRAM port. Arbitration is fixed-priority for data with a starvation guard for fetch. Out-of-range accesses return a bus error. The SRAM keeps its 1-cycle read latency, and every grant gets exactly one response.

## Interface
Parameters:
- MemStart, 32'h00000000, byte base address of the SRAM window
- MemSize, 65536, SRAM size in bytes; a power of two, at least 8
- MaxDataStreak, 4, consecutive contended data grants before fetch is forced through; range 1–15
- MemAw, $clog2(MemSize/4), derived word-address width

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
- data_req_i  in  1  load/store request
- data_we_i  in  1  store when 1
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid; asserted for stores as well as loads
- data_rdata_o  out  32  load data
- data_err_o  out  1  data error, qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MemAw  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o

## Operation
- In range means (addr & ~(MemSize-1)) == MemStart. Word address = addr[MemAw+1:2]. addr[1:0] is ignored.
- At most one grant per cycle. Grant is combinational from the current request, address and streak counter.
- Arbitration:
  - Only one requester: that requester is granted.
  - Both requesting: data wins, unless streak_q == MaxDataStreak, in which case instr wins.
- Streak counter streak_q (4 bits, reset 0):
  - Increments on a data grant while instr_req_i is high.
  - Clears on an instr grant, or on any cycle in which instr_req_i is low.
  - Never exceeds MaxDataStreak.
- Granted in-range access: mem_req_o=1 and mem_addr_o/be/we/wdata come from the winner.
  - Instruction accesses drive we=0, be=4'hF, wdata=0.
- Granted out-of-range access: consumes the slot with mem_req_o=0. The response carries err=1 and rdata=0. A store is dropped.
- Response registers, set in the grant cycle and cleared otherwise: rsp_instr_q, rsp_data_q, rsp_err_q.
  - x_rvalid_o = rsp_x_q.
  - x_err_o = rsp_x_q & rsp_err_q.
  - x_rdata_o = mem_rdata_i when rsp_x_q & !rsp_err_q, else 0.
- No backpressure on responses; requesters accept rvalid unconditionally.
- Idle (no request): mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.

## Timing
- Reset values:
  - All gnt, rvalid and err outputs 0; rdata outputs 0.
  - mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o 0 while requests are low.
  - streak_q 0.
- Latency: gnt in cycle N, then rvalid exactly in cycle N+1, including for error responses.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating requesters are allowed with no bubble.
- Requester protocol: req may be held across cycles; each high-gnt cycle is a distinct transaction. Address and data are sampled only in grant cycles.
- Simultaneous requests at the starvation threshold: the instr grant and the streak clear happen in the same cycle, and data is retried the next cycle.
- Reset asserted mid-transaction: pending responses are dropped and no rvalid is produced after reset release. Outputs go to reset values asynchronously.
- Write followed by a read of the same word on the next cycle returns the new data (SRAM read-after-write ordering, one access per cycle).

## Test plan
- Single fetch: instr_req=1, addr 0x80, SRAM word 32 = 0x00000013. Required: gnt same cycle, mem_addr_o=32; next cycle instr_rvalid=1, rdata=0x00000013, err=0.
- Store then load: data store be=4'b0011, wdata 0xAABBCCDD to 0x100, then load from 0x100 over old value 0x11223344. Required: store rvalid with err=0, then load rdata=0x1122CCDD.
- Contention: both requesting continuously with MaxDataStreak=4. Required: grant pattern D,D,D,D,I repeating, and streak_q returns to 0 after each I.
- Out-of-range: data load at 0x00010000 (MemSize 64 KiB). Required: gnt=1, mem_req_o=0; next cycle data_rvalid=1, err=1, rdata=0. Also an out-of-range store leaves SRAM unchanged.
- Interleaved streams: fetch every cycle, data every other cycle. Required: every grant matched by exactly one rvalid on the correct port one cycle later, with data matching the scoreboard.
- Reset mid-operation: assert rst_sys_n low in the cycle after a grant. Required: rvalid stays 0, streak_q=0, and the first post-reset fetch behaves like the single-fetch case.
